// File: rtl/seq_shift_pkg.sv
// Shared types and constants for the sequential right-shift unit.
// Imported by the step datapath and the sequencer.
package seq_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic SHIFT_LOGICAL = 1'b0;
  localparam logic SHIFT_ARITH   = 1'b1;

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit right shift.
// Fills the vacated MSB with the sign bit or with zero.
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in,
  input  logic             arith,
  output logic [WIDTH-1:0] out
);

  logic fill;

  assign fill = (arith == SHIFT_ARITH) ? in[WIDTH-1] : 1'b0;
  assign out  = (in >> 1) | {fill, {(WIDTH-1){1'b0}}};

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle right shifter, one bit per clock.
// Valid/ready on both sides; latency depends only on the amount.
module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] step;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .in   (acc_q),
    .arith(mode_q),
    .out  (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= SHIFT_LOGICAL;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = in_data;
          cnt_d   = in_amt;
          mode_d  = in_arith;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Every requested step runs, so amounts >= WIDTH saturate.
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q - {{(AMT_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Randomized bench for seq_shift_unit.
// Reference uses native shift operators on the whole operand.
module tb_seq_shift_unit;

  localparam int W  = 4;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [AW-1:0] in_amt;
  logic          in_arith;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;

  int checks;
  int failures;

  seq_shift_unit #(
    .WIDTH(W),
    .AMT_W(AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_arith (in_arith),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d,
                                             input int amt,
                                             input bit ar);
    logic signed [W-1:0] sd;
    logic [W-1:0]        ud;
    if (ar) begin
      sd = d;
      sd = sd >>> amt;
      return sd;
    end
    ud = d >> amt;
    return ud;
  endfunction

  task automatic junk();
    in_valid = 1'($urandom);
    in_data  = W'($urandom);
    in_amt   = AW'($urandom);
    in_arith = 1'($urandom);
  endtask

  task automatic run_req(input logic [W-1:0] d, input int amt,
                         input bit ar, input int hold);
    logic [W-1:0] exp;
    int k;
    bit seen;
    exp = ref_shift(d, amt, ar);
    chk("pre_rdy", in_ready, 1);
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = amt[AW-1:0];
    in_arith  = ar;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    chk("acc_busy", busy, 1);
    junk();
    k = 0;
    seen = 0;
    while (!seen && k < 20) begin
      @(posedge clk); #1;
      k++;
      seen = out_valid;
      if (!seen) chk("shift_rdy", in_ready, 0);
      junk();
    end
    chk("lat", k, amt + 1);
    chk("data", out_data, exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_v", out_valid, 1);
      chk("hold_d", out_data, exp);
      chk("hold_rdy", in_ready, 0);
      junk();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_v", out_valid, 0);
    chk("post_rdy", in_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    int k;
    bit anyv;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_arith  = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_rdy", in_ready, 1);
    chk("rst_v", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req(4'b1010, 1, 1'b1, 0);
    run_req(4'b1010, 1, 1'b0, 0);
    run_req(4'b1010, 0, 1'b0, 0);
    run_req(4'b1010, 7, 1'b1, 0);
    run_req(4'b1010, 7, 1'b0, 0);
    run_req(4'b0110, 7, 1'b1, 0);
    run_req(4'b1010, 1, 1'b1, 3);
    chk("ex_arith", ref_shift(4'b1010, 1, 1'b1), 4'b1101);

    // Reset during SHIFT drops the request.
    in_valid = 1'b1;
    in_data  = 4'b1011;
    in_amt   = 3'd5;
    in_arith = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v", out_valid, 0);
    chk("mid_rst_rdy", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_d", out_data, 0);
    #2;
    rst_n = 1'b1;
    anyv = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) anyv = 1;
    end
    chk("mid_no_v", anyv, 0);
    run_req(4'b1000, 2, 1'b1, 0);

    // Back-to-back with in_valid held high.
    in_valid  = 1'b1;
    in_data   = 4'b1011;
    in_amt    = 3'd2;
    in_arith  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_data  = 4'b0110;
    in_amt   = 3'd1;
    in_arith = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("b2b_lat1", k, 3);
    chk("b2b_d1", out_data, ref_shift(4'b1011, 2, 1'b1));
    @(posedge clk); #1;
    chk("b2b_rdy", in_ready, 1);
    chk("b2b_v0", out_valid, 0);
    @(posedge clk); #1;
    chk("b2b_acc", busy, 1);
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("b2b_lat2", k, 2);
    chk("b2b_d2", out_data, ref_shift(4'b0110, 1, 1'b0));
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end", out_valid, 0);

    for (int n = 0; n < 40; n++) begin
      run_req(W'($urandom), int'($urandom_range(0, 7)),
              1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_shift_unit.md
# seq_shift_unit

Multi-cycle right-shift unit that applies a programmable number of one-bit right shifts to a WIDTH-bit operand, one bit per clock. It supports arithmetic (sign-filling) and logical (zero-filling) modes. It sits directly upstream of the consumer that needs shifted operands and wraps the one-bit arithmetic/logical right-shift step in a sequencer with valid/ready handshakes on both sides.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits (≥2)
- AMT_W, 3, shift-amount width; amounts 0..2^AMT_W-1 are legal, including amounts ≥ WIDTH

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  unit can accept a request
- in_data  in  WIDTH  operand
- in_amt  in  AMT_W  number of one-bit shifts
- in_arith  in  1  1 = arithmetic (fill with MSB), 0 = logical (fill with 0)
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- out_data  out  WIDTH  shifted result
- busy  out  1  request in flight (state SHIFT or DONE)

## Operation
- One clock domain. Reset is asynchronous and active-low.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready at an edge: latch in_data→acc, in_amt→cnt, in_arith→mode; go to SHIFT.
- SHIFT:
  - If cnt==0: go to DONE, acc unchanged.
  - Else: acc ← {mode ? acc[WIDTH-1] : 0, acc[WIDTH-1:1]}, cnt ← cnt-1.
- DONE:
  - out_valid=1, out_data=acc.
  - When out_ready is high at an edge: go to IDLE.
- in_ready=0 in SHIFT and DONE. Inputs are ignored there and are not queued.
- Every shift executes; there is no early exit. Latency depends only on in_amt.
- Amounts ≥ WIDTH saturate naturally:
  - arithmetic gives all copies of the sign bit;
  - logical gives all zeros.
- Example (WIDTH=4, 1010): arith amt1 = 1101, logic amt1 = 0101.
- out_data is held stable while out_valid=1 and out_ready=0.
- out_data outside DONE: holds acc (don't-care for consumers; the bench checks it only when out_valid=1).

## Timing
- Reset values: in_ready=1 (once rst_n deasserts, state IDLE), out_valid=0, busy=0, out_data=0. Internal acc=0, cnt=0, mode=0.
- Counting from the accept edge E0, DONE is entered at edge E(amt+1). out_valid is high in the cycle after that edge.
  - amt=0: out_valid in the cycle after E1.
  - amt=7: out_valid in the cycle after E8.
- Throughput: one request per amt+3 cycles minimum. The earliest next accept is the edge after the out handshake edge, because in_ready rises only in IDLE.
- out_valid never drops without a handshake.
- rst_n asserted mid-operation (SHIFT or DONE): immediately forces IDLE and the reset values above. The in-flight request is discarded and no out_valid is produced for it.
- in_valid deasserted or in_data changed while not in IDLE: no effect.

## Structure
- Shared package seq_shift_pkg contains:
  - state typedef (IDLE/SHIFT/DONE);
  - mode constants SHIFT_LOGICAL=0 and SHIFT_ARITH=1.
- One sub-module, shift_step: a parameterized combinational one-bit right shift with inputs in[WIDTH], arith and output out[WIDTH]. The FSM instantiates it once on acc.
- FSM and datapath registers live in seq_shift_unit. Registers reset asynchronously on negedge rst_n.

## Test plan
- Reset, then in_data=1010, in_arith=1, in_amt=1, out_ready=1 → out_valid in the cycle after E2, out_data=1101, then in_ready=1 one cycle later.
- in_data=1010, in_arith=0, in_amt=1 → out_data=0101; in_amt=0 → out_data=1010 with out_valid after E1.
- Saturation, in_amt=7 on 1010: arith → 1111, logic → 0000. out_valid after E8. Also 0110 arith amt 7 → 0000.
- Backpressure: result 1101 with out_ready low for 3 cycles → out_valid and out_data=1101 held stable; in_ready=0 and in_valid pulses are ignored; IDLE follows the edge where out_ready goes high.
- Reset mid-shift: in_amt=5, pull rst_n low during SHIFT → outputs go to reset values immediately; after release no out_valid appears. A fresh request 1000 arith amt2 → 1110.
- Back-to-back: two requests with in_valid held continuously → the second is accepted exactly one edge after the first out handshake, and both results are correct.
